// File: rtl/switch_debouncer.sv
// rtl/switch_debouncer.sv - synchronise, debounce and edge-detect eight switches, hold last one-hot selection
module switch_debouncer #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] ui_in,
  output logic [7:0] sw_stable,
  output logic [7:0] sw_rise,
  output logic [7:0] sw_fall,
  output logic       onehot_valid,
  output logic [7:0] sel_out,
  output logic       sel_valid,
  output logic       sel_changed
);

  // Counter only has to reach DEBOUNCE_CYCLES-1, so clog2 of the window is enough.
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Two-flop synchroniser; only the second stage is safe to use.
  logic [7:0] r_sync1;
  logic [7:0] r_sync2;

  // Debounced state, registered edge pulses and per-bit window counters.
  logic [7:0]       r_stable;
  logic [7:0]       r_rise;
  logic [7:0]       r_fall;
  logic [CNT_W-1:0] r_cnt [8];

  // Next-state values for the debounce stage.
  logic [7:0]       w_stable_nxt;
  logic [7:0]       w_rise_nxt;
  logic [7:0]       w_fall_nxt;
  logic [CNT_W-1:0] w_cnt_nxt [8];

  // Selection register fed from the registered debounced level.
  logic [7:0] r_sel_out;
  logic       r_sel_valid;
  logic       r_sel_changed;
  logic       w_onehot;

  // Bring the raw asynchronous levels into the clock domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 8'h00;
      r_sync2 <= 8'h00;
    end else begin
      r_sync1 <= ui_in;
      r_sync2 <= r_sync1;
    end
  end

  // Per-bit window: any sample that agrees with the stable level restarts the count,
  // so a bit flipping back on the would-be expiry edge is discarded as well.
  always_comb begin
    w_stable_nxt = r_stable;
    w_rise_nxt   = 8'h00;
    w_fall_nxt   = 8'h00;
    for (int i = 0; i < 8; i++) begin
      w_cnt_nxt[i] = r_cnt[i];
      if (r_sync2[i] == r_stable[i]) begin
        w_cnt_nxt[i] = '0;
      end else if (r_cnt[i] == CNT_MAX) begin
        w_cnt_nxt[i]    = '0;
        w_stable_nxt[i] = r_sync2[i];
        w_rise_nxt[i]   = r_sync2[i];
        w_fall_nxt[i]   = ~r_sync2[i];
      end else begin
        w_cnt_nxt[i] = r_cnt[i] + CNT_ONE;
      end
    end
  end

  // Commit debounced level, edge pulses and counters together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stable <= 8'h00;
      r_rise   <= 8'h00;
      r_fall   <= 8'h00;
      for (int i = 0; i < 8; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_stable <= w_stable_nxt;
      r_rise   <= w_rise_nxt;
      r_fall   <= w_fall_nxt;
      for (int i = 0; i < 8; i++) begin
        r_cnt[i] <= w_cnt_nxt[i];
      end
    end
  end

  // Exactly one bit set: non-zero and clearing the lowest set bit leaves nothing.
  always_comb begin
    w_onehot = (r_stable != 8'h00) && ((r_stable & (r_stable - 8'd1)) == 8'h00);
  end

  // Capture every one-hot debounced value; zero or multi-hot leaves the selection untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sel_out     <= 8'h00;
      r_sel_valid   <= 1'b0;
      r_sel_changed <= 1'b0;
    end else if (w_onehot) begin
      r_sel_out     <= r_stable;
      r_sel_valid   <= 1'b1;
      r_sel_changed <= (r_stable != r_sel_out);
    end else begin
      r_sel_changed <= 1'b0;
    end
  end

  assign sw_stable    = r_stable;
  assign sw_rise      = r_rise;
  assign sw_fall      = r_fall;
  assign onehot_valid = w_onehot;
  assign sel_out      = r_sel_out;
  assign sel_valid    = r_sel_valid;
  assign sel_changed  = r_sel_changed;

endmodule
